// File: rtl/exec_decode_unit_pkg.sv
// Shared encodings for the decode/execute slice: opcodes, funct codes, ALUOp and ALU control
// values, plus the main control decode.
package exec_decode_unit_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_NOR = 6'h27;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  typedef struct packed {
    logic       jump;
    logic       branch;
    logic       bne;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic       reg_dst;
    logic [1:0] alu_op;
  } ctrl_t;

  // mem_to_reg=1 selects the ALU result at write-back, 0 selects load data.
  function automatic ctrl_t decode_ctrl(input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_RTYPE: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
        c.reg_dst    = 1'b1;
        c.alu_op     = ALUOP_FUNCT;
      end
      OP_LW: begin
        c.mem_read  = 1'b1;
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
      end
      OP_SW: begin
        c.mem_write = 1'b1;
        c.alu_src   = 1'b1;
      end
      OP_BEQ: begin
        c.branch = 1'b1;
        c.alu_op = ALUOP_SUB;
      end
      OP_BNE: begin
        c.bne    = 1'b1;
        c.alu_op = ALUOP_SUB;
      end
      OP_J: c.jump = 1'b1;
      OP_ADDI: begin
        c.mem_to_reg = 1'b1;
        c.alu_src    = 1'b1;
        c.reg_write  = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/exec_decode_unit_if.sv
// Instruction/operand inputs and registered control/result outputs of the decode/execute slice.
interface exec_decode_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic [31:0]      instr;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;

  logic             jump;
  logic             branch;
  logic             bne;
  logic             mem_read;
  logic             mem_to_reg;
  logic             mem_write;
  logic             alu_src;
  logic             reg_write;
  logic             reg_dst;
  logic [1:0]       alu_op;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] result;
  logic             zero;

  modport master (
    output instr, rs_data, rt_data,
    input  jump, branch, bne, mem_read, mem_to_reg, mem_write, alu_src, reg_write, reg_dst,
    input  alu_op, alu_ctrl, result, zero
  );

  modport slave (
    input  instr, rs_data, rt_data,
    output jump, branch, bne, mem_read, mem_to_reg, mem_write, alu_src, reg_write, reg_dst,
    output alu_op, alu_ctrl, result, zero
  );
endinterface

// File: rtl/exec_decode_unit_alu_core.sv
// Combinational ALU: applies a 4-bit ALU control code to operands a and b.
module alu_core
  import exec_decode_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [3:0]       i_alu_ctrl,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result
);

  logic w_lt;
  assign w_lt = $signed(i_a) < $signed(i_b);

  always_comb begin
    o_result = '0;
    case (i_alu_ctrl)
      ALU_AND: o_result = i_a & i_b;
      ALU_OR:  o_result = i_a | i_b;
      ALU_ADD: o_result = i_a + i_b;
      ALU_SUB: o_result = i_a - i_b;
      ALU_SLT: o_result = {{(WIDTH-1){1'b0}}, w_lt};
      ALU_NOR: o_result = ~(i_a | i_b);
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/exec_decode_unit.sv
// Decode-and-execute slice: control decode, ALU-control mapping, ALU, one output register stage.
module exec_decode_unit
  import exec_decode_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  exec_decode_unit_if.slave   bus
);

  ctrl_t            w_ctrl;
  logic [3:0]       w_alu_ctrl;
  logic [WIDTH-1:0] w_imm_ext;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_result;

  ctrl_t            r_ctrl;
  logic [3:0]       r_alu_ctrl;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;

  assign w_ctrl = decode_ctrl(bus.instr[31:26]);

  always_comb begin
    w_alu_ctrl = ALU_ADD;
    case (w_ctrl.alu_op)
      ALUOP_ADD: w_alu_ctrl = ALU_ADD;
      ALUOP_SUB: w_alu_ctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (bus.instr[5:0])
          FUNCT_ADD: w_alu_ctrl = ALU_ADD;
          FUNCT_SUB: w_alu_ctrl = ALU_SUB;
          FUNCT_AND: w_alu_ctrl = ALU_AND;
          FUNCT_OR:  w_alu_ctrl = ALU_OR;
          FUNCT_NOR: w_alu_ctrl = ALU_NOR;
          FUNCT_SLT: w_alu_ctrl = ALU_SLT;
          default:   w_alu_ctrl = ALU_ADD;
        endcase
      end
      default: w_alu_ctrl = ALU_ADD;
    endcase
  end

  assign w_imm_ext = {{(WIDTH-16){bus.instr[15]}}, bus.instr[15:0]};
  assign w_b       = w_ctrl.alu_src ? w_imm_ext : bus.rt_data;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_alu_core (
    .i_alu_ctrl (w_alu_ctrl),
    .i_a        (bus.rs_data),
    .i_b        (w_b),
    .o_result   (w_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl     <= '0;
      r_alu_ctrl <= '0;
      r_result   <= '0;
      r_zero     <= 1'b0;
    end else begin
      r_ctrl     <= w_ctrl;
      r_alu_ctrl <= w_alu_ctrl;
      r_result   <= w_result;
      r_zero     <= (w_result == '0);
    end
  end

  assign bus.jump       = r_ctrl.jump;
  assign bus.branch     = r_ctrl.branch;
  assign bus.bne        = r_ctrl.bne;
  assign bus.mem_read   = r_ctrl.mem_read;
  assign bus.mem_to_reg = r_ctrl.mem_to_reg;
  assign bus.mem_write  = r_ctrl.mem_write;
  assign bus.alu_src    = r_ctrl.alu_src;
  assign bus.reg_write  = r_ctrl.reg_write;
  assign bus.reg_dst    = r_ctrl.reg_dst;
  assign bus.alu_op     = r_ctrl.alu_op;
  assign bus.alu_ctrl   = r_alu_ctrl;
  assign bus.result     = r_result;
  assign bus.zero       = r_zero;

endmodule

// File: tb/tb_exec_decode_unit.sv
// Bench for exec_decode_unit: directed vector table, reset sequences, random vs reference model.
module tb_exec_decode_unit;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  exec_decode_unit_if #(.WIDTH(32)) bus ();

  exec_decode_unit #(
    .WIDTH (32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flag order: jump,branch,bne,mem_read,mem_to_reg,mem_write,alu_src,reg_write,reg_dst,alu_op
  localparam logic [10:0] F_R    = 11'b0_0_0_0_1_0_0_1_1_10;
  localparam logic [10:0] F_LW   = 11'b0_0_0_1_0_0_1_1_0_00;
  localparam logic [10:0] F_SW   = 11'b0_0_0_0_0_1_1_0_0_00;
  localparam logic [10:0] F_BEQ  = 11'b0_1_0_0_0_0_0_0_0_01;
  localparam logic [10:0] F_BNE  = 11'b0_0_1_0_0_0_0_0_0_01;
  localparam logic [10:0] F_J    = 11'b1_0_0_0_0_0_0_0_0_00;
  localparam logic [10:0] F_ADDI = 11'b0_0_0_0_1_0_1_1_0_00;
  localparam logic [10:0] F_NOP  = 11'b0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [10:0] flags;
    logic [3:0]  actl;
    logic [31:0] res;
    logic        z;
  } vec_t;

  typedef struct {
    logic [10:0] flags;
    logic [3:0]  actl;
    logic [31:0] res;
    logic        z;
  } exp_t;

  vec_t tbl [16];

  // Reference model straight from the instruction-set tables.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] rs,
                                 input logic [31:0] rt);
    exp_t        e;
    logic [31:0] b;
    longint      sa;
    longint      sb;
    case (ins[31:26])
      6'h00:   e.flags = F_R;
      6'h23:   e.flags = F_LW;
      6'h2B:   e.flags = F_SW;
      6'h04:   e.flags = F_BEQ;
      6'h05:   e.flags = F_BNE;
      6'h02:   e.flags = F_J;
      6'h08:   e.flags = F_ADDI;
      default: e.flags = F_NOP;
    endcase
    e.actl = 4'b0010;
    if (e.flags[1:0] == 2'b01) e.actl = 4'b0110;
    else if (e.flags[1:0] == 2'b10) begin
      if (ins[5:0] == 6'h22) e.actl = 4'b0110;
      else if (ins[5:0] == 6'h24) e.actl = 4'b0000;
      else if (ins[5:0] == 6'h25) e.actl = 4'b0001;
      else if (ins[5:0] == 6'h27) e.actl = 4'b1100;
      else if (ins[5:0] == 6'h2A) e.actl = 4'b0111;
    end
    b  = e.flags[4] ? {{16{ins[15]}}, ins[15:0]} : rt;
    sa = longint'($signed(rs));
    sb = longint'($signed(b));
    if (e.actl == 4'b0010)      e.res = 32'(sa + sb);
    else if (e.actl == 4'b0110) e.res = 32'(sa - sb);
    else if (e.actl == 4'b0000) e.res = rs & b;
    else if (e.actl == 4'b0001) e.res = rs | b;
    else if (e.actl == 4'b1100) e.res = ~(rs | b);
    else                        e.res = (sa < sb) ? 32'd1 : 32'd0;
    e.z = (e.res == 32'd0);
    return e;
  endfunction

  function automatic logic [10:0] dut_flags();
    return {bus.jump, bus.branch, bus.bne, bus.mem_read, bus.mem_to_reg, bus.mem_write,
            bus.alu_src, bus.reg_write, bus.reg_dst, bus.alu_op};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, " flags"}, 32'(dut_flags()), 32'(e.flags));
    chk({tag, " alu_ctrl"}, 32'(bus.alu_ctrl), 32'(e.actl));
    chk({tag, " result"}, bus.result, e.res);
    chk({tag, " zero"}, 32'(bus.zero), 32'(e.z));
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    bus.instr   = ins;
    bus.rs_data = rs;
    bus.rt_data = rt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  exp_t zero_e;
  exp_t e;

  initial begin
    n_checks = 0;
    n_errors = 0;
    zero_e   = '{flags: 11'b0, actl: 4'b0, res: 32'b0, z: 1'b0};

    tbl[0]  = '{32'h0000_0000, 32'h0,         32'h0,         F_R,    4'b0010, 32'h0,         1'b1};
    tbl[1]  = '{32'h0022_1820, 32'd5,         32'd7,         F_R,    4'b0010, 32'd12,        1'b0};
    tbl[2]  = '{32'h0022_1822, 32'd7,         32'd7,         F_R,    4'b0110, 32'h0,         1'b1};
    tbl[3]  = '{32'h0022_182A, 32'hFFFF_FFFF, 32'd1,         F_R,    4'b0111, 32'd1,         1'b0};
    tbl[4]  = '{32'h0022_182A, 32'd1,         32'hFFFF_FFFF, F_R,    4'b0111, 32'd0,         1'b1};
    tbl[5]  = '{32'h0022_1825, 32'hF0F0_F0F0, 32'h0F0F_0F0F, F_R,    4'b0001, 32'hFFFF_FFFF, 1'b0};
    tbl[6]  = '{32'h0022_1827, 32'hF0F0_F0F0, 32'h0F0F_0F0F, F_R,    4'b1100, 32'h0,         1'b1};
    tbl[7]  = '{32'h0022_1824, 32'hF0F0_F0F0, 32'h0F0F_0F0F, F_R,    4'b0000, 32'h0,         1'b1};
    tbl[8]  = '{32'h8C22_0004, 32'h100,       32'hDEAD,      F_LW,   4'b0010, 32'h104,       1'b0};
    tbl[9]  = '{32'hAC22_FFFC, 32'h100,       32'hBEEF,      F_SW,   4'b0010, 32'hFC,        1'b0};
    tbl[10] = '{32'h1022_0003, 32'd9,         32'd9,         F_BEQ,  4'b0110, 32'h0,         1'b1};
    tbl[11] = '{32'h1422_0003, 32'd9,         32'd4,         F_BNE,  4'b0110, 32'd5,         1'b0};
    tbl[12] = '{32'h0800_0010, 32'd3,         32'd4,         F_J,    4'b0010, 32'd7,         1'b0};
    tbl[13] = '{32'hFC00_0000, 32'd3,         32'd4,         F_NOP,  4'b0010, 32'd7,         1'b0};
    tbl[14] = '{32'h2022_FFFF, 32'd10,        32'd99,        F_ADDI, 4'b0010, 32'd9,         1'b0};
    tbl[15] = '{32'h0022_1821, 32'd2,         32'd3,         F_R,    4'b0010, 32'd5,         1'b0};

    // Reset held with live inputs: outputs must stay cleared across edges.
    rst_n = 1'b0;
    drive(32'h0022_1820, 32'd5, 32'd7);
    step();
    step();
    chk_all("reset_hold", zero_e);

    // Release mid-cycle; first valid output on the next edge.
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].instr, tbl[i].rs, tbl[i].rt);
      step();
      e = '{flags: tbl[i].flags, actl: tbl[i].actl, res: tbl[i].res, z: tbl[i].z};
      chk_all($sformatf("vec%0d", i), e);
    end

    // Asynchronous reset between edges during a stream.
    drive(32'h8C22_0004, 32'h100, 32'h0);
    step();
    chk_all("pre_async", model(32'h8C22_0004, 32'h100, 32'h0));
    drive(32'h0022_1820, 32'd5, 32'd7);
    #3;
    rst_n = 1'b0;
    #1;
    chk_all("async_clear", zero_e);
    step();
    chk_all("async_hold", zero_e);
    #2;
    rst_n = 1'b1;
    step();
    chk_all("async_resume", model(32'h0022_1820, 32'd5, 32'd7));

    // Random stream against the model.
    for (int i = 0; i < 400; i++) begin
      logic [5:0]  ops [8];
      logic [5:0]  fns [7];
      logic [31:0] ins;
      logic [31:0] rs;
      logic [31:0] rt;
      ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h08, 6'h00};
      fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h20};
      ins = $urandom;
      if ($urandom_range(0, 4) != 0) ins[31:26] = ops[$urandom_range(0, 7)];
      if ($urandom_range(0, 4) != 0) ins[5:0]   = fns[$urandom_range(0, 6)];
      rs = $urandom;
      rt = $urandom;
      case ($urandom_range(0, 5))
        0: rt = rs;
        1: rs = 32'h8000_0000;
        2: rt = 32'h7FFF_FFFF;
        default: ;
      endcase
      drive(ins, rs, rt);
      step();
      chk_all($sformatf("rand%0d", i), model(ins, rs, rt));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/exec_decode_unit.md
Name: exec_decode_unit

Overview:
- Single-cycle decode-and-execute slice for the 5-stage MIPS pipeline.
- Decodes a 32-bit instruction into main control signals and a 2-bit ALUOp, maps ALUOp and funct to a 4-bit ALU operation, and executes that operation on the supplied operands.
- All results are captured in one output register stage; EX/MEM logic consumes the registered outputs.

Parameters:
- WIDTH, 32, datapath width of operands and result.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- instr  in  32  instruction word; opcode = [31:26], funct = [5:0], imm = [15:0]
- rs_data  in  WIDTH  first ALU operand
- rt_data  in  WIDTH  second operand, used when ALUSrc=0
- jump, branch, bne  out  1 each  registered control flags
- mem_read, mem_to_reg, mem_write, alu_src, reg_write, reg_dst  out  1 each  registered control flags
- alu_op  out  2  registered ALUOp
- alu_ctrl  out  4  registered ALU operation code
- result  out  WIDTH  registered ALU result
- zero  out  1  registered flag, 1 when the result is 0

Behaviour:
- Reset (rst_n=0, asynchronous) clears every output to 0 immediately; outputs stay 0 while rst_n is low.
- Latency: all outputs update on the rising clk edge after the inputs are presented. Latency is 1 cycle with throughput 1 per cycle. There is no handshake and no stall input.
- Control decode (jump, branch, bne, mem_read, mem_to_reg, mem_write, alu_src, reg_write, reg_dst, alu_op):
  - R-type, op 0x00: 0,0,0,0,1,0,0,1,1,10
  - lw, op 0x23: 0,0,0,1,0,0,1,1,0,00
  - sw, op 0x2B: 0,0,0,0,0,1,1,0,0,00
  - beq, op 0x04: 0,1,0,0,0,0,0,0,0,01
  - bne, op 0x05: 0,0,1,0,0,0,0,0,0,01
  - j, op 0x02: 1,0,0,0,0,0,0,0,0,00
  - addi, op 0x08: 0,0,0,0,1,0,1,1,0,00
  - any other opcode: all flags 0 and alu_op 00 (NOP). Such an instruction writes no register and no memory.
- mem_to_reg polarity is fixed: 0 selects memory load data and 1 selects the ALU result. This matches the write-back mux (sel=1 selects input b).
- ALU control mapping:
  - alu_op 00 gives ADD 0010.
  - alu_op 01 gives SUB 0110.
  - alu_op 10 decodes funct: 0x20 ADD 0010, 0x22 SUB 0110, 0x24 AND 0000, 0x25 OR 0001, 0x27 NOR 1100, 0x2A SLT 0111.
  - Unknown funct, and alu_op 11, give ADD 0010.
- Operand B = alu_src ? sign-extended instr[15:0] : rt_data.
- ALU operations:
  - ADD/SUB use modulo 2^WIDTH wrap-around with no overflow trap.
  - SLT is a signed compare and returns 1 or 0, zero-extended.
  - AND, OR and NOR are bitwise.
  - Any undefined alu_ctrl value returns 0.
- zero is computed from the unregistered result and registered alongside it.
- If reset is asserted mid-stream, the in-flight result is discarded. The first valid output after release appears on the first rising edge with rst_n=1.

Decomposition:
- Shared package holds opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI), funct constants, ALUOp encodings, and ALU control codes (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR).
- A single combinational sub-module, alu_core, performs alu_ctrl, a, b to result. Control decode, ALU-control mapping and the output register live in the top.

Test Plan:
- Hold rst_n=0 with nonzero inputs, then clock: all outputs 0. Deassert, apply NOP instr 0x00000000: result 0, zero=1, reg_write=1, alu_ctrl 0010.
- R-type add instr 0x00221820, rs=5, rt=7: next edge gives result=12, zero=0, reg_dst=1, alu_op=10. Then sub funct 0x22 with rs=7, rt=7 gives result 0, zero=1, alu_ctrl 0110.
- slt instr funct 0x2A, rs=0xFFFFFFFF, rt=1: result=1. Swap the operands: result=0. Also check or (0x25) and nor (0x27) with rs=0xF0F0F0F0, rt=0x0F0F0F0F: OR gives 0xFFFFFFFF, NOR gives 0.
- lw instr 0x8C220004, rs=0x100: result=0x104, mem_read=1, mem_to_reg=0, alu_src=1. sw 0xAC22FFFC, rs=0x100: result=0xFC, mem_write=1, reg_write=0.
- beq op 0x04 gives branch=1, alu_op=01, alu_ctrl 0110. bne gives bne=1. j 0x08000010 gives jump=1 and all other flags 0. Opcode 0x3F gives all flags 0.
- Assert rst_n low asynchronously between edges during a stream: outputs clear immediately without waiting for a clock. After release the stream resumes with 1-cycle latency.
